// File: rtl/pebble_game_pkg.sv
// Shared types for the pebble game: FSM state encoding and winner codes.
package pebble_game_pkg;

  typedef enum logic [1:0] {
    WAIT_PLAYER = 2'd0,
    AI_THINK    = 2'd1,
    AI_MOVE     = 2'd2,
    GAME_OVER   = 2'd3
  } state_t;

  localparam logic [1:0] WIN_NONE   = 2'b00;
  localparam logic [1:0] WIN_PLAYER = 2'b01;
  localparam logic [1:0] WIN_AI     = 2'b10;

endpackage

// File: rtl/pebble_ai_sel.sv
// AI move selection: highest-index nonzero pile, take min(pile, MAX_TAKE).
// Ports:
//   pos    - flattened pile counts, pile i at [i*CNT_W +: CNT_W]
//   index  - selected pile (0 when every pile is empty)
//   amount - pebbles to remove from the selected pile (0 when every pile is empty)
module pebble_ai_sel #(
  parameter int unsigned NUM_POS  = 4,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned MAX_TAKE = 2
) (
  input  logic [NUM_POS*CNT_W-1:0]   pos,
  output logic [$clog2(NUM_POS)-1:0] index,
  output logic [CNT_W-1:0]           amount
);

  localparam int unsigned POS_W = $clog2(NUM_POS);

  // Ascending scan so the last nonzero pile seen (highest index) wins.
  always_comb begin
    index  = '0;
    amount = '0;
    for (int i = 0; i < NUM_POS; i++) begin
      if (pos[i*CNT_W +: CNT_W] != '0) begin
        index  = POS_W'(i);
        amount = (32'(pos[i*CNT_W +: CNT_W]) > MAX_TAKE) ? CNT_W'(MAX_TAKE)
                                                        : pos[i*CNT_W +: CNT_W];
      end
    end
  end

endmodule

// File: rtl/pebble_game_n.sv
// N-pile pebble game: player vs. a fixed-strategy AI with a think delay.
// Ports:
//   clock           - single clock, rising edge
//   reset           - asynchronous, active-low
//   play            - move request, acted on at its rising edge only
//   player_position - selected pile
//   player_take     - pebbles requested
//   winner          - 00 none, 01 player, 10 AI
//   pos             - flattened pile counts, pile i at [i*CNT_W +: CNT_W]
//   busy            - high during the AI turn
//   illegal         - one-cycle pulse on a rejected player move
//   move_count      - saturating count of all moves (only with PEBBLE_GAME_MOVE_CNT_EN)
module pebble_game_n #(
  parameter int unsigned NUM_POS      = 4,
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned INIT_PEBBLES = 3,
  parameter int unsigned MAX_TAKE     = 2,
  parameter int unsigned AI_DELAY     = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         play,
  input  logic [$clog2(NUM_POS)-1:0]   player_position,
  input  logic [$clog2(MAX_TAKE+1)-1:0] player_take,
  output logic [1:0]                   winner,
  output logic [NUM_POS*CNT_W-1:0]     pos,
  output logic                         busy,
  output logic                         illegal
`ifdef PEBBLE_GAME_MOVE_CNT_EN
  ,
  output logic [7:0]                   move_count
`endif
);

  import pebble_game_pkg::*;

  localparam int unsigned POS_W   = $clog2(NUM_POS);
  localparam int unsigned THINK_W = $clog2(AI_DELAY + 1);

  state_t               state;
  logic                 play_q;
  logic [THINK_W-1:0]   think_cnt;
  logic [CNT_W-1:0]     pile_q            [NUM_POS];
  logic [CNT_W-1:0]     pile_after_player [NUM_POS];
  logic [CNT_W-1:0]     pile_after_ai     [NUM_POS];
  logic [CNT_W-1:0]     sel_pile;
  logic [POS_W-1:0]     ai_index;
  logic [CNT_W-1:0]     ai_amount;
  logic                 pos_ok;
  logic                 legal;
  logic                 move_evt;
  logic                 player_all_zero;
  logic                 ai_all_zero;

  // Flatten pile registers onto the output bus.
  always_comb begin
    pos = '0;
    for (int i = 0; i < NUM_POS; i++) begin
      pos[i*CNT_W +: CNT_W] = pile_q[i];
    end
  end

  pebble_ai_sel #(
    .NUM_POS  (NUM_POS),
    .CNT_W    (CNT_W),
    .MAX_TAKE (MAX_TAKE)
  ) u_ai_sel (
    .pos    (pos),
    .index  (ai_index),
    .amount (ai_amount)
  );

  // Player move legality and resulting piles for both move kinds.
  always_comb begin
    move_evt        = play && !play_q;
    pos_ok          = 32'(player_position) < NUM_POS;
    sel_pile        = pos_ok ? pile_q[player_position] : '0;
    legal           = pos_ok && (player_take != '0) &&
                      (32'(player_take) <= MAX_TAKE) &&
                      (32'(player_take) <= 32'(sel_pile));
    player_all_zero = 1'b1;
    ai_all_zero     = 1'b1;
    for (int i = 0; i < NUM_POS; i++) begin
      // Underflow only on illegal requests, whose result is discarded.
      pile_after_player[i] = (pos_ok && (32'(player_position) == 32'(i)))
                             ? pile_q[i] - CNT_W'(player_take) : pile_q[i];
      pile_after_ai[i]     = (32'(ai_index) == 32'(i))
                             ? pile_q[i] - ai_amount : pile_q[i];
      if (pile_after_player[i] != '0) player_all_zero = 1'b0;
      if (pile_after_ai[i] != '0)     ai_all_zero     = 1'b0;
    end
  end

  // Game FSM with registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= WAIT_PLAYER;
      play_q    <= 1'b0;
      think_cnt <= '0;
      winner    <= WIN_NONE;
      busy      <= 1'b0;
      illegal   <= 1'b0;
      for (int i = 0; i < NUM_POS; i++) pile_q[i] <= CNT_W'(INIT_PEBBLES);
`ifdef PEBBLE_GAME_MOVE_CNT_EN
      move_count <= 8'd0;
`endif
    end else begin
      play_q  <= play;
      illegal <= 1'b0;
      case (state)
        WAIT_PLAYER: begin
          if (move_evt) begin
            if (legal) begin
              pile_q <= pile_after_player;
`ifdef PEBBLE_GAME_MOVE_CNT_EN
              if (move_count != 8'hFF) move_count <= move_count + 8'd1;
`endif
              if (player_all_zero) begin
                state  <= GAME_OVER;
                winner <= WIN_PLAYER;
              end else begin
                state     <= AI_THINK;
                think_cnt <= THINK_W'(AI_DELAY);
                busy      <= 1'b1;
              end
            end else begin
              illegal <= 1'b1;
            end
          end
        end
        AI_THINK: begin
          think_cnt <= think_cnt - THINK_W'(1);
          if (think_cnt <= THINK_W'(1)) state <= AI_MOVE;
        end
        AI_MOVE: begin
          pile_q <= pile_after_ai;
          busy   <= 1'b0;
`ifdef PEBBLE_GAME_MOVE_CNT_EN
          if (move_count != 8'hFF) move_count <= move_count + 8'd1;
`endif
          if (ai_all_zero) begin
            state  <= GAME_OVER;
            winner <= WIN_AI;
          end else begin
            state <= WAIT_PLAYER;
          end
        end
        GAME_OVER: begin
          state <= GAME_OVER;
        end
        default: state <= WAIT_PLAYER;
      endcase
    end
  end

endmodule

// File: tb/tb_pebble_game_n.sv
// Directed bench for pebble_game_n (4 piles, 4-bit counts, 3 pebbles, take<=2, think 2).
module tb_pebble_game_n;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        play  = 1'b0;
  logic [1:0]  player_position = '0;
  logic [1:0]  player_take     = '0;
  logic [1:0]  winner;
  logic [15:0] pos;
  logic        busy;
  logic        illegal;
`ifdef PEBBLE_GAME_MOVE_CNT_EN
  logic [7:0]  move_count;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [15:0] pos;
    logic [1:0]  winner;
    logic        busy;
    logic        illegal;
  } exp_t;

  exp_t sb[$];

  pebble_game_n #(
    .NUM_POS(4), .CNT_W(4), .INIT_PEBBLES(3), .MAX_TAKE(2), .AI_DELAY(2)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .play            (play),
    .player_position (player_position),
    .player_take     (player_take),
    .winner          (winner),
    .pos             (pos),
    .busy            (busy),
    .illegal         (illegal)
`ifdef PEBBLE_GAME_MOVE_CNT_EN
    ,
    .move_count      (move_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input string tag, input logic [15:0] p, input logic [1:0] w,
                      input logic b, input logic il);
    exp_t e;
    e.tag = tag; e.pos = p; e.winner = w; e.busy = b; e.illegal = il;
    sb.push_back(e);
  endtask

  task automatic pop();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty observed=0 expected>=1 entries");
    end else begin
      e = sb.pop_front();
      checks++;
      assert (pos === e.pos) else begin
        failures++;
        $error("FAIL %s pos observed=%h expected=%h", e.tag, pos, e.pos);
      end
      checks++;
      assert (winner === e.winner) else begin
        failures++;
        $error("FAIL %s winner observed=%b expected=%b", e.tag, winner, e.winner);
      end
      checks++;
      assert (busy === e.busy) else begin
        failures++;
        $error("FAIL %s busy observed=%b expected=%b", e.tag, busy, e.busy);
      end
      checks++;
      assert (illegal === e.illegal) else begin
        failures++;
        $error("FAIL %s illegal observed=%b expected=%b", e.tag, illegal, e.illegal);
      end
    end
  endtask

  // Full player turn followed by the AI turn; a second play edge during AI_THINK must be ignored.
  task automatic turn(input string tag, input logic [1:0] p, input logic [1:0] t,
                      input logic [15:0] after_p, input logic [15:0] after_ai,
                      input logic [1:0] win_ai);
    player_position = p; player_take = t; play = 1'b1;
    push({tag, "_player"}, after_p, 2'b00, 1'b1, 1'b0);
    tick(); pop();
    play = 1'b0;
    push({tag, "_think1"}, after_p, 2'b00, 1'b1, 1'b0);
    tick(); pop();
    play = 1'b1;
    push({tag, "_think2"}, after_p, 2'b00, 1'b1, 1'b0);
    tick(); pop();
    play = 1'b0;
    push({tag, "_ai"}, after_ai, win_ai, 1'b0, 1'b0);
    tick(); pop();
  endtask

  task automatic try_illegal(input string tag, input logic [1:0] p, input logic [1:0] t,
                             input logic [15:0] cur);
    player_position = p; player_take = t; play = 1'b1;
    push({tag, "_pulse"}, cur, 2'b00, 1'b0, 1'b1);
    tick(); pop();
    play = 1'b0;
    push({tag, "_after"}, cur, 2'b00, 1'b0, 1'b0);
    tick(); pop();
  endtask

  initial begin
    // Reset and release.
    push("in_reset", 16'h3333, 2'b00, 1'b0, 1'b0);
    tick(); pop();
    reset = 1'b1;
    push("post_reset", 16'h3333, 2'b00, 1'b0, 1'b0);
    tick(); pop();

    // Player takes 2 from pile1; AI takes 2 from pile3 three cycles later.
    turn("move1", 2'd1, 2'd2, 16'h3313, 16'h1313, 2'b00);

    // Held play: single decrement of pile0, then AI takes pile3's last pebble.
    player_position = 2'd0; player_take = 2'd1; play = 1'b1;
    push("held_e0", 16'h1312, 2'b00, 1'b1, 1'b0); tick(); pop();
    push("held_e1", 16'h1312, 2'b00, 1'b1, 1'b0); tick(); pop();
    push("held_e2", 16'h1312, 2'b00, 1'b1, 1'b0); tick(); pop();
    push("held_e3", 16'h0312, 2'b00, 1'b0, 1'b0); tick(); pop();
    push("held_e4", 16'h0312, 2'b00, 1'b0, 1'b0); tick(); pop();
    play = 1'b0;
    push("held_rel", 16'h0312, 2'b00, 1'b0, 1'b0); tick(); pop();

    // Rejected moves: piles are p3=0 p2=3 p1=1 p0=2.
    try_illegal("take3",      2'd0, 2'd3, 16'h0312);
    try_illegal("take0",      2'd2, 2'd0, 16'h0312);
    try_illegal("empty_pile", 2'd3, 2'd1, 16'h0312);
    try_illegal("over_pile",  2'd1, 2'd2, 16'h0312);

    // Play on so the player takes the last pebble.
    turn("g1", 2'd2, 2'd1, 16'h0212, 16'h0012, 2'b00);
    turn("g2", 2'd0, 2'd1, 16'h0011, 16'h0001, 2'b00);
    player_position = 2'd0; player_take = 2'd1; play = 1'b1;
    push("player_wins", 16'h0000, 2'b01, 1'b0, 1'b0); tick(); pop();
    play = 1'b0;
    push("over_idle", 16'h0000, 2'b01, 1'b0, 1'b0); tick(); pop();
    player_position = 2'd1; player_take = 2'd3; play = 1'b1;
    push("over_ignored", 16'h0000, 2'b01, 1'b0, 1'b0); tick(); pop();
    play = 1'b0;
    push("over_hold", 16'h0000, 2'b01, 1'b0, 1'b0); tick(); pop();

    // Reset in the middle of AI_THINK abandons the AI move.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    player_position = 2'd1; player_take = 2'd1; play = 1'b1;
    push("mid_player", 16'h3323, 2'b00, 1'b1, 1'b0); tick(); pop();
    play = 1'b0;
    reset = 1'b0;
    #1;
    push("mid_async", 16'h3333, 2'b00, 1'b0, 1'b0); pop();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push("mid_no_ai", 16'h3333, 2'b00, 1'b0, 1'b0); tick(); pop();
    end
`ifdef PEBBLE_GAME_MOVE_CNT_EN
    checks++;
    assert (move_count === 8'd0) else begin
      failures++;
      $error("FAIL mid_move_count observed=%0d expected=0", move_count);
    end
`endif

    // AI empties the last pile.
    turn("a1", 2'd3, 2'd2, 16'h1333, 16'h0333, 2'b00);
    turn("a2", 2'd2, 2'd2, 16'h0133, 16'h0033, 2'b00);
    turn("a3", 2'd1, 2'd2, 16'h0013, 16'h0003, 2'b00);
`ifdef PEBBLE_GAME_MOVE_CNT_EN
    checks++;
    assert (move_count === 8'd6) else begin
      failures++;
      $error("FAIL move_count observed=%0d expected=6", move_count);
    end
`endif
    turn("a4", 2'd0, 2'd2, 16'h0001, 16'h0000, 2'b10);
    push("ai_hold", 16'h0000, 2'b10, 1'b0, 1'b0); tick(); pop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pebble_game_n.md
PEBBLE_GAME_N -- requirements
Module: pebble_game_n

Interface
REQ-001 SHALL have parameter NUM_POS, default 4: number of pebble piles, range 2..16.
REQ-002 SHALL have parameter CNT_W, default 4: pile counter width.
REQ-003 SHALL have parameter INIT_PEBBLES, default 3: reset value of every pile; must be <= 2^CNT_W-1.
REQ-004 SHALL have parameter MAX_TAKE, default 2: maximum pebbles taken per move; must be >= 1.
REQ-005 SHALL have parameter AI_DELAY, default 2: AI think cycles; must be >= 1.
REQ-006 SHALL have port: clock  input  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port: play  input  1  player move request; only its rising edge is acted on.
REQ-009 SHALL have port: player_position  input  $clog2(NUM_POS)  index of the selected pile.
REQ-010 SHALL have port: player_take  input  $clog2(MAX_TAKE+1)  number of pebbles requested.
REQ-011 SHALL have port: winner  output  2  00 none, 01 player, 10 AI, 11 never driven.
REQ-012 SHALL have port: pos  output  NUM_POS*CNT_W  flattened pile counts; pile i at bits [i*CNT_W +: CNT_W].
REQ-013 SHALL have port: busy  output  1  high while the AI turn is in progress.
REQ-014 SHALL have port: illegal  output  1  one-cycle pulse flagging a rejected player move.

Function
REQ-015 SHALL implement FSM states WAIT_PLAYER, AI_THINK, AI_MOVE and GAME_OVER; reset state is WAIT_PLAYER.
REQ-016 SHALL register play into play_q; a move event is play=1 with play_q=0 at a clock edge. Held play yields exactly one event.
REQ-017 In WAIT_PLAYER, a move is legal when: player_position < NUM_POS; 1 <= player_take <= MAX_TAKE; player_take <= selected pile.
REQ-018 On a legal event, SHALL subtract player_take from the selected pile at that edge, so pos updates the next cycle.
REQ-019 After a legal move, if all piles are zero, SHALL enter GAME_OVER with winner=01; otherwise SHALL enter AI_THINK, load the think counter and set busy=1.
REQ-020 On an illegal event, SHALL pulse illegal for exactly one cycle, leave piles and state unchanged, and not latch the request.
REQ-021 AI_THINK SHALL last exactly AI_DELAY cycles, then move to AI_MOVE.
REQ-022 In AI_MOVE (one cycle), SHALL pick the highest-index nonzero pile and subtract min(pile, MAX_TAKE) from it.
REQ-023 After the AI move, SHALL enter GAME_OVER with winner=10 if all piles are zero; otherwise SHALL return to WAIT_PLAYER with busy=0.
REQ-024 Move events arriving during AI_THINK, AI_MOVE or GAME_OVER SHALL be ignored silently: no illegal pulse, no state change.
REQ-025 GAME_OVER SHALL hold winner and pos until reset.
REQ-026 Subtraction SHALL be done in CNT_W bits and never underflow, which REQ-017 and REQ-022 guarantee.

Reset
REQ-027 While reset=0, SHALL asynchronously set: every pile = INIT_PEBBLES, winner=00, busy=0, illegal=0, play_q=0, think counter=0, state=WAIT_PLAYER.
REQ-028 Reset asserted mid-AI_THINK or mid-game SHALL abandon the turn with no pending AI move after release.

Configuration
REQ-029 With macro PEBBLE_GAME_MOVE_CNT_EN defined, SHALL add output move_count (8 bits, saturating at 255): +1 per legal player move and +1 per AI move, reset to 0.
REQ-030 Without PEBBLE_GAME_MOVE_CNT_EN, the move_count port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-031 Package pebble_game_pkg SHALL hold the FSM state enum and the winner encodings (WIN_NONE, WIN_PLAYER, WIN_AI).
REQ-032 AI pile selection and take-amount computation SHALL live in combinational sub-module pebble_ai_sel: inputs pos, outputs index and amount.

Verification (NUM_POS=4, CNT_W=4, INIT=3, MAX_TAKE=2, AI_DELAY=2)
REQ-033 Release reset -> pos = {3,3,3,3}, winner=00, busy=0, illegal=0.
REQ-034 play rising edge, position=1, take=2 -> next cycle pile1=1, busy=1; pile3 becomes 1 exactly 3 cycles later; busy=0.
REQ-035 play held high 5 cycles with position=0, take=1 -> pile0 decrements once only.
REQ-036 Move with take=3, take=0 or take > pile -> illegal high one cycle; pos unchanged; FSM stays in WAIT_PLAYER.
REQ-037 Sequence leaving the player to empty the last pile -> winner=01 and busy stays 0; later play edges change nothing.
REQ-038 Reset asserted during AI_THINK -> pos = {3,3,3,3}, no AI decrement after release; with the macro defined, move_count=0.
